// File: rtl/altr_hps_tie_cfg_seq.sv
// ---------------------------------------------------------------------------
// altr_hps_tie_cfg_seq
//
// Programmable tie-off controller. Holds WIDTH constant-drive outputs that
// come out of reset at DEFAULT (tie-high). Run-time changes go through a
// masked shadow register and are copied to tie_out by a 4-phase apply
// handshake. A settle window follows each copy before apply_ack is raised.
//
// Optional feature macro: ALTR_HPS_TIE_CFG_LOCK_EN
//   When it is defined, cfg_lock sets a sticky lock bit that only rst
//   clears. While the lock is set, writes and applies still complete their
//   handshakes but change neither the shadow nor tie_out.
//   When it is undefined, cfg_lock is ignored and locked is tied to 0.
//
// Handshakes:
//   cfg    : a write transfers on a rising clk edge where cfg_valid and
//            cfg_ready are both high. cfg_ready depends only on state and
//            never on cfg_valid. A source that sees ready low must hold its
//            data and valid.
//   apply  : 4-phase. apply_req is raised and held. apply_ack rises when
//            the settle window has ended. apply_req then drops, and
//            apply_ack drops on the next edge.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   cfg_valid/ready    shadow write handshake
//   cfg_data/cfg_mask  write data and per-bit write enable
//   apply_req/ack      apply handshake
//   tie_out            registered tie values
//   dirty              shadow differs from tie_out
//   busy               settle window or waiting for apply_req to drop
//   cfg_lock/locked    lock request and status (feature build only)
//   state_dbg          current FSM state: 0 IDLE, 1 STAGED, 2 SETTLE, 3 DONE
// ---------------------------------------------------------------------------
module altr_hps_tie_cfg_seq #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] DEFAULT    = {WIDTH{1'b1}},
  parameter int               SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             apply_req,
  output logic             apply_ack,
  output logic [WIDTH-1:0] tie_out,
  output logic             dirty,
  output logic             busy,
  input  logic             cfg_lock,
  output logic             locked,
  output logic [1:0]       state_dbg
);

  // $clog2(1) is 0, so a zero-length settle window still gets a 1-bit counter.
  localparam int CW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STAGED = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] tie_q, tie_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lock_active;
  logic             write_fire;
  logic             apply_fire;

`ifdef ALTR_HPS_TIE_CFG_LOCK_EN
  logic locked_q, locked_d;

  // The lock is sticky: it is set in any state, and only reset clears it.
  always_comb begin
    locked_d = locked_q | cfg_lock;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) locked_q <= 1'b0;
    else     locked_q <= locked_d;
  end

  assign lock_active = locked_q;
  assign locked      = locked_q;
`else
  logic unused_cfg_lock;
  assign unused_cfg_lock = cfg_lock;
  assign lock_active     = 1'b0;
  assign locked          = 1'b0;
`endif

  assign cfg_ready  = (state_q == ST_IDLE) || (state_q == ST_STAGED);
  assign write_fire = cfg_valid && cfg_ready;
  // A write in the same cycle has priority. The apply waits for a later
  // cycle so that it copies the updated shadow.
  assign apply_fire = apply_req && cfg_ready && !cfg_valid;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    tie_d    = tie_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE, ST_STAGED: begin
        if (write_fire) begin
          if (!lock_active) begin
            shadow_d = (shadow_q & ~cfg_mask) | (cfg_data & cfg_mask);
          end
          state_d = ST_STAGED;
        end else if (apply_fire) begin
          if (!lock_active) begin
            tie_d = shadow_q;
          end
          cnt_d   = CW'(SETTLE_CYC);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_DONE: begin
        if (!apply_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shadow_q <= DEFAULT;
      tie_q    <= DEFAULT;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      tie_q    <= tie_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tie_out   = tie_q;
  assign apply_ack = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_DONE);
  assign dirty     = (shadow_q != tie_q);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_altr_hps_tie_cfg_seq.sv
// ---------------------------------------------------------------------------
// Testbench for altr_hps_tie_cfg_seq (WIDTH=16, SETTLE_CYC=4).
// Inputs change on the falling edge. Outputs are checked on the next
// falling edge, after the rising edge that acted on those inputs.
// ---------------------------------------------------------------------------
module tb_altr_hps_tie_cfg_seq;

  localparam int W      = 16;
  localparam int SETTLE = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [W-1:0]  cfg_data  = '0;
  logic [W-1:0]  cfg_mask  = '0;
  logic          apply_req = 1'b0;
  logic          apply_ack;
  logic [W-1:0]  tie_out;
  logic          dirty;
  logic          busy;
  logic          cfg_lock  = 1'b0;
  logic          locked;
  logic [1:0]    state_dbg;

  altr_hps_tie_cfg_seq #(.WIDTH(W), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_mask(cfg_mask),
    .apply_req(apply_req), .apply_ack(apply_ack),
    .tie_out(tie_out), .dirty(dirty), .busy(busy),
    .cfg_lock(cfg_lock), .locked(locked), .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: after an accepted apply, ack appears exactly
  // SETTLE+1 edges later. The model counts down those edges, with no FSM.
  logic [W-1:0] m_shadow, m_tie;
  int           m_to_ack;   // edges left until ack; -1 means no apply in flight
  bit           m_ack;
  bit           model_en = 1'b0;

  function automatic bit m_busy();
    return (m_to_ack >= 0) || m_ack;
  endfunction

  task automatic model_reset();
    m_shadow = 16'hFFFF;
    m_tie    = 16'hFFFF;
    m_to_ack = -1;
    m_ack    = 1'b0;
  endtask

  task automatic model_edge();
    if (!m_busy() && cfg_valid) begin
      m_shadow = (m_shadow & ~cfg_mask) | (cfg_data & cfg_mask);
    end else if (!m_busy() && apply_req) begin
      m_tie    = m_shadow;
      m_to_ack = SETTLE + 1;
    end else if (m_to_ack > 0) begin
      m_to_ack--;
      if (m_to_ack == 0) begin
        m_to_ack = -1;
        m_ack    = 1'b1;
      end
    end else if (m_ack && !apply_req) begin
      m_ack = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    if (model_en) model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic [W-1:0] m, input logic a);
    cfg_valid = v;
    cfg_data  = d;
    cfg_mask  = m;
    apply_req = a;
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    step();
    rst = 1'b0;
    step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic [W-1:0] m;
    logic         a;
    logic [W-1:0] e_tie;
    logic         e_rdy;
    logic         e_ack;
    logic         e_busy;
    logic         e_dirty;
    logic [1:0]   e_st;
  } vec_t;

  vec_t vecs[21];

  initial begin
    int n;
    int ack_wait;
    logic [W-1:0] exp_lock_tie;
    logic         exp_locked;

    // Masked write, then apply: ack comes 5 edges after acceptance.
    vecs[0]  = '{1'b1, 16'h0000, 16'h00F0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[1]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFF0F, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[2]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFF0F, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFF0F, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFF0F, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFF0F, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFF0F, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3};
    vecs[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFF0F, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3};
    vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'hFF0F, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    // Same-cycle collision in STAGED: the write wins and the apply waits.
    vecs[9]  = '{1'b1, 16'h00FF, 16'hFFFF, 1'b0, 16'hFF0F, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[10] = '{1'b1, 16'h1234, 16'hFFFF, 1'b1, 16'hFF0F, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[11] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    // Write backpressure during SETTLE/DONE: valid is held.
    vecs[12] = '{1'b1, 16'hABCD, 16'hFFFF, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[13] = '{1'b1, 16'hABCD, 16'hFFFF, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[14] = '{1'b1, 16'hABCD, 16'hFFFF, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[15] = '{1'b1, 16'hABCD, 16'hFFFF, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[16] = '{1'b1, 16'hABCD, 16'hFFFF, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3};
    vecs[17] = '{1'b1, 16'hABCD, 16'hFFFF, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[18] = '{1'b1, 16'hABCD, 16'hFFFF, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[19] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    // A zero-mask write is still accepted and leaves the shadow unchanged.
    vecs[20] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};

    // ---- reset state ----
    @(negedge clk);
    @(negedge clk);
    check("rst_tie",   32'(tie_out),   32'hFFFF);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_ack",   32'(apply_ack), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_dirty", 32'(dirty),     32'd0);
    check("rst_lock",  32'(locked),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ---- table ----
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].m, vecs[i].a);
      step();
      check($sformatf("vec%0d_tie", i),   32'(tie_out),   32'(vecs[i].e_tie));
      check($sformatf("vec%0d_rdy", i),   32'(cfg_ready), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d_ack", i),   32'(apply_ack), 32'(vecs[i].e_ack));
      check($sformatf("vec%0d_busy", i),  32'(busy),      32'(vecs[i].e_busy));
      check($sformatf("vec%0d_dirty", i), 32'(dirty),     32'(vecs[i].e_dirty));
      check($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(vecs[i].e_st));
    end

    // ---- randomized against the model ----
    sync_reset();
    model_reset();
    model_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) == 0), 16'($urandom), 16'($urandom),
            ($urandom_range(0, 4) != 0));
      step();
      check("rnd_tie",   32'(tie_out),   32'(m_tie));
      check("rnd_ready", 32'(cfg_ready), 32'(!m_busy()));
      check("rnd_ack",   32'(apply_ack), 32'(m_ack));
      check("rnd_busy",  32'(busy),      32'(m_busy()));
      check("rnd_dirty", 32'(dirty),     32'(m_shadow != m_tie));
    end
    model_en = 1'b0;

    // ---- async reset in the second SETTLE cycle ----
    sync_reset();
    drive(1'b1, 16'h0000, 16'hFFFF, 1'b0);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b1);
    step();                                  // acceptance edge
    check("mid_tie_applied", 32'(tie_out), 32'h0000);
    step();                                  // second SETTLE cycle
    rst = 1'b1;
    #1;
    check("mid_tie",   32'(tie_out),   32'hFFFF);
    check("mid_ready", 32'(cfg_ready), 32'd1);
    check("mid_ack",   32'(apply_ack), 32'd0);
    check("mid_busy",  32'(busy),      32'd0);
    check("mid_dirty", 32'(dirty),     32'd0);
    check("mid_state", 32'(state_dbg), 32'd0);
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_ack", 32'(apply_ack), 32'd0);
      check("post_rst_tie", 32'(tie_out),   32'hFFFF);
    end

    // ---- apply_req dropped during SETTLE: ack for exactly one cycle ----
    drive(1'b0, 16'h0000, 16'h0000, 1'b1);
    step();                                  // apply from IDLE re-drives FFFF
    check("drop_tie", 32'(tie_out), 32'hFFFF);
    check("drop_busy", 32'(busy), 32'd1);
    apply_req = 1'b0;
    for (int i = 0; i < SETTLE; i++) step();
    check("drop_pre_ack", 32'(apply_ack), 32'd0);
    step();
    check("drop_ack_hi", 32'(apply_ack), 32'd1);
    step();
    check("drop_ack_lo", 32'(apply_ack), 32'd0);
    check("drop_state",  32'(state_dbg), 32'd0);

    // ---- lock behaviour ----
`ifdef ALTR_HPS_TIE_CFG_LOCK_EN
    exp_lock_tie = 16'hFFFF;
    exp_locked   = 1'b1;
`else
    exp_lock_tie = 16'h0000;
    exp_locked   = 1'b0;
`endif
    cfg_lock = 1'b1;
    step();
    cfg_lock = 1'b0;
    drive(1'b1, 16'h0000, 16'hFFFF, 1'b0);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b1);
    step();                                  // acceptance edge
    check("lock_tie_accept", 32'(tie_out), 32'(exp_lock_tie));
    ack_wait = 0;
    n = 0;
    while (!apply_ack && n < 20) begin
      step();
      n++;
    end
    ack_wait = n;
    check("lock_ack_seen", 32'(apply_ack), 32'd1);
    check("lock_ack_cyc",  32'(ack_wait),  32'(SETTLE + 1));
    check("lock_locked",   32'(locked),    32'(exp_locked));
    check("lock_tie",      32'(tie_out),   32'(exp_lock_tie));
    apply_req = 1'b0;
    step();
    check("lock_idle_ack", 32'(apply_ack), 32'd0);
    check("lock_tie_end",  32'(tie_out),   32'(exp_lock_tie));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
